// File: rtl/multi_edge_detector_pkg.sv
// Shared parameters and types for the multi-channel edge detector.
package multi_edge_detector_pkg;

    localparam int unsigned WIDTH_DEF       = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned FILTER_LEN_DEF  = 4;

    // Edge decision produced by a channel filter on a given cycle.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Width of a persistence counter able to count up to filter_len.
    function automatic int unsigned cnt_width(input int unsigned filter_len);
        return $clog2(filter_len + 1);
    endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// Signal bundle between the edge detector and its user.
// master: drives raw inputs, enables and clears; slave: returns level, edges, status, irq.
interface multi_edge_detector_if
    import multi_edge_detector_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] rise_en_i;
    logic [WIDTH-1:0] fall_en_i;
    logic [WIDTH-1:0] clear_i;
    logic [WIDTH-1:0] level_o;
    logic [WIDTH-1:0] rising_edge_o;
    logic [WIDTH-1:0] falling_edge_o;
    logic [WIDTH-1:0] status_o;
    logic             irq_o;

    modport master (
        output a_i, rise_en_i, fall_en_i, clear_i,
        input  level_o, rising_edge_o, falling_edge_o, status_o, irq_o
    );

    modport slave (
        input  a_i, rise_en_i, fall_en_i, clear_i,
        output level_o, rising_edge_o, falling_edge_o, status_o, irq_o
    );

endinterface

// File: rtl/multi_edge_detector_chan.sv
// One channel: synchroniser, persistence filter, filtered level and edge pulses.
// Ports: clk, reset_n, a (raw async input), level (filtered), rise/fall (one-cycle pulses).
module edge_det_chan
    import multi_edge_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_c;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   level_d;
    edge_e                  edge_c;

    assign s_c = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a};
        end
    end

    // Counter restarts on any return to level; the level flips on the last count.
    always_comb begin
        cnt_d   = '0;
        level_d = level;
        edge_c  = EDGE_NONE;
        if (s_c != level) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s_c;
                edge_c  = s_c ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Filter state and registered edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            level <= level_d;
            rise  <= (edge_c == EDGE_RISE);
            fall  <= (edge_c == EDGE_FALL);
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector with sticky, clearable status and an interrupt.
// Ports: clk, reset_n (async active-low), bus (slave side: a_i, rise_en_i, fall_en_i,
// clear_i in; level_o, rising_edge_o, falling_edge_o, status_o, irq_o out).
module multi_edge_detector
    import multi_edge_detector_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned FILTER_LEN  = FILTER_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    multi_edge_detector_if.slave   bus
);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] set_c;
    logic             irq_q;

    // Independent per-channel filters.
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .a       (bus.a_i[g]),
            .level   (level_q[g]),
            .rise    (rise_q[g]),
            .fall    (fall_q[g])
        );
    end

    // Enabled edges set status; set wins over a simultaneous clear.
    always_comb begin
        set_c    = (rise_q & bus.rise_en_i) | (fall_q & bus.fall_en_i);
        status_d = set_c | (status_q & ~bus.clear_i);
    end

    // irq is taken from the next-status value so it moves with status_o.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= |status_d;
        end
    end

    assign bus.level_o        = level_q;
    assign bus.rising_edge_o  = rise_q;
    assign bus.falling_edge_o = fall_q;
    assign bus.status_o       = status_q;
    assign bus.irq_o          = irq_q;

endmodule
